rr_grant_arbiter: RTL

- Four-requester round-robin arbiter; produces a registered one-hot grant plus grant_valid.
- Sits directly upstream of the one-hot-to-binary encoder stage: grant drives the encoder's one-hot input, grant_valid drives its enable.
- Guarantees grant is always one-hot or all-zero, so the encoder never sees an undecodable code.
- Holds ownership per requester until release, request drop, or hold timeout.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 36 +++
 rtl/rr_grant_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin grant arbiter.
// Owner index decode is kept here so the top and any bench helper agree on it.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int ARB_N        = 4;
   localparam int ARB_MAX_HOLD = 15;
   localparam int ARB_CW       = 8;

   // Index of the lowest set bit; a one-hot value yields its position, zero yields 0.
   function automatic int unsigned onehot_idx(input logic [31:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Requests are doubled so the wrap becomes a plain lowest-set-bit search.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N  = ARB_N,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  pick_onehot,
   output logic          any_req
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] masked;
   logic [2*N-1:0] lowest;

   assign dbl = {req, req};

   // Lower copy only contributes bits at or above ptr; upper copy covers the wrap.
   generate
      for (genvar gi = 0; gi < 2*N; gi++) begin : g_mask
         if (gi >= N) begin : g_hi
            assign masked[gi] = dbl[gi];
         end else begin : g_lo
            assign masked[gi] = dbl[gi] & (gi >= int'(ptr));
         end
      end
   endgenerate

   assign lowest      = masked & (~masked + 1'b1);
   assign pick_onehot = lowest[N-1:0] | lowest[2*N-1:N];
   assign any_req     = |req;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, tenure hold and timeout.
// Feeds a one-hot-to-binary encoder: grant is always one-hot or zero.
module rr_grant_arbiter
   import arb_pkg::*;
#(
   parameter int N        = ARB_N,
   parameter int MAX_HOLD = ARB_MAX_HOLD,
   parameter int CW       = ARB_CW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         release_grant,
   output logic [N-1:0] grant,
   output logic         grant_valid,
   output logic         timeout
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   state_t         state_reg, state_next;
   logic [N-1:0]   grant_reg, grant_next;
   logic           grant_valid_reg, grant_valid_next;
   logic           timeout_reg, timeout_next;
   logic [PW-1:0]  ptr_reg, ptr_next;
   logic [CW-1:0]  hold_cnt_reg, hold_cnt_next;

   logic [N-1:0]   pick_onehot;
   logic           any_req;
   logic [PW-1:0]  owner_idx;
   logic           user_end;
   logic           hold_hit;

   rr_pick #(.N(N), .PW(PW)) u_pick (
      .req         (req),
      .ptr         (ptr_reg),
      .pick_onehot (pick_onehot),
      .any_req     (any_req)
   );

   assign owner_idx = PW'(onehot_idx(32'(grant_reg)));
   assign user_end  = release_grant | ~(|(req & grant_reg));
   assign hold_hit  = (hold_cnt_reg == CW'(MAX_HOLD));

   always_comb begin
      state_next       = state_reg;
      grant_next       = grant_reg;
      grant_valid_next = grant_valid_reg;
      timeout_next     = 1'b0;
      ptr_next         = ptr_reg;
      hold_cnt_next    = hold_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               grant_next       = pick_onehot;
               grant_valid_next = 1'b1;
               hold_cnt_next    = CW'(1);
               state_next       = GRANT;
            end
         end
         GRANT: begin
            if (user_end || hold_hit) begin
               grant_next       = '0;
               grant_valid_next = 1'b0;
               ptr_next         = (owner_idx == PW'(N-1)) ? '0 : owner_idx + 1'b1;
               hold_cnt_next    = '0;
               state_next       = IDLE;
               // A voluntary end in the same cycle is not a revocation.
               timeout_next     = hold_hit & ~user_end;
            end else begin
               hold_cnt_next = hold_cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         grant_reg       <= '0;
         grant_valid_reg <= 1'b0;
         timeout_reg     <= 1'b0;
         ptr_reg         <= '0;
         hold_cnt_reg    <= '0;
      end else begin
         state_reg       <= state_next;
         grant_reg       <= grant_next;
         grant_valid_reg <= grant_valid_next;
         timeout_reg     <= timeout_next;
         ptr_reg         <= ptr_next;
         hold_cnt_reg    <= hold_cnt_next;
      end
   end

   assign grant       = grant_reg;
   assign grant_valid = grant_valid_reg;
   assign timeout     = timeout_reg;

   a_grant_legal: assert property (@(posedge clk) disable iff (rst)
      $onehot0(grant_reg) && (grant_valid_reg == (|grant_reg)));

endmodule
